// File: rtl/bullet_hit_scanner.sv
// Per-frame collision scan of the 8 bullet-table slots against the player box, followed by a
// single HP commit that applies damage, healing and invulnerability frames.
module bullet_hit_scanner #(
    parameter int unsigned HP_MAX  = 20,
    parameter int unsigned DAMAGE  = 4,
    parameter int unsigned HEAL    = 1,
    parameter int unsigned IFRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  bullet_index,
    input  logic [15:0] bullet_position,
    input  logic [15:0] bullet_size,
    input  logic [2:0]  bullet_color,
    input  logic        bullet_render,
    input  logic [15:0] player_position,
    input  logic [15:0] player_size,
    input  logic        player_moving,
    output logic [7:0]  hp,
    output logic        hit,
    output logic        heal,
    output logic        dead,
    output logic        iframe_active,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IfW = $clog2(IFRAMES + 2);

    localparam logic [7:0]     HpMax   = 8'(HP_MAX);
    localparam logic [7:0]     DmgAmt  = 8'(DAMAGE);
    localparam logic [8:0]     HealAmt = 9'(HEAL);
    localparam logic [IfW-1:0] IfLoad  = IfW'(IFRAMES);

    localparam logic [2:0] ColWhite = 3'b000;
    localparam logic [2:0] ColGreen = 3'b001;
    localparam logic [2:0] ColBlue  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StApply
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     index_q, index_d;
    logic [15:0]    ppos_q, ppos_d;
    logic [15:0]    psize_q, psize_d;
    logic           pmov_q, pmov_d;
    logic           dmg_flag_q, dmg_flag_d;
    logic           heal_flag_q, heal_flag_d;
    logic [7:0]     hp_q, hp_d;
    logic [IfW-1:0] ifr_q, ifr_d;
    logic           hit_q, hit_d;
    logic           heal_q, heal_d;
    logic           done_q, done_d;
    logic           dead_q, dead_d;
    logic           ifa_q, ifa_d;

    // Zero-extended to 9 bits so box edge sums cannot wrap.
    logic [8:0] bx, by, bw, bh, px, py, pw, ph;
    logic       nonzero_boxes;
    logic       overlap;

    assign bx = {1'b0, bullet_position[15:8]};
    assign by = {1'b0, bullet_position[7:0]};
    assign bw = {1'b0, bullet_size[15:8]};
    assign bh = {1'b0, bullet_size[7:0]};
    assign px = {1'b0, ppos_q[15:8]};
    assign py = {1'b0, ppos_q[7:0]};
    assign pw = {1'b0, psize_q[15:8]};
    assign ph = {1'b0, psize_q[7:0]};

    // Strict compares alone would let a zero-width box sit inside the other one.
    assign nonzero_boxes = (bw != 9'd0) && (bh != 9'd0) && (pw != 9'd0) && (ph != 9'd0);

    assign overlap = nonzero_boxes &&
                     (bx < px + pw) && (px < bx + bw) &&
                     (by < py + ph) && (py < by + bh);

    logic [7:0] hp_damaged;
    logic [8:0] hp_heal_sum;
    logic [7:0] hp_healed;

    assign hp_damaged  = (hp_q > DmgAmt) ? hp_q - DmgAmt : 8'd0;
    assign hp_heal_sum = {1'b0, hp_q} + HealAmt;
    assign hp_healed   = (hp_heal_sum >= {1'b0, HpMax}) ? HpMax : hp_heal_sum[7:0];

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        ppos_d      = ppos_q;
        psize_d     = psize_q;
        pmov_d      = pmov_q;
        dmg_flag_d  = dmg_flag_q;
        heal_flag_d = heal_flag_q;
        hp_d        = hp_q;
        ifr_d       = ifr_q;
        dead_d      = dead_q;
        ifa_d       = ifa_q;
        hit_d       = 1'b0;
        heal_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ppos_d      = player_position;
                    psize_d     = player_size;
                    pmov_d      = player_moving;
                    dmg_flag_d  = 1'b0;
                    heal_flag_d = 1'b0;
                    index_d     = 3'd0;
                    state_d     = StScan;
                end
            end

            StScan: begin
                if (bullet_render && overlap) begin
                    case (bullet_color)
                        ColWhite: dmg_flag_d  = 1'b1;
                        ColBlue:  dmg_flag_d  = dmg_flag_q | pmov_q;
                        ColGreen: heal_flag_d = 1'b1;
                        default:  ;
                    endcase
                end
                index_d = index_q + 3'd1;
                if (index_q == 3'd7) begin
                    state_d = StApply;
                end
            end

            StApply: begin
                if (!dead_q) begin
                    if (dmg_flag_q && (ifr_q == '0)) begin
                        hp_d  = hp_damaged;
                        hit_d = 1'b1;
                    end else if (!dmg_flag_q && heal_flag_q) begin
                        // Damage absorbed by iframes still suppresses healing.
                        hp_d   = hp_healed;
                        heal_d = (hp_healed != hp_q);
                    end
                end

                if (ifr_q != '0) begin
                    ifr_d = ifr_q - 1'b1;
                end else if (hit_d) begin
                    ifr_d = IfLoad;
                end

                dead_d  = dead_q | (hp_d == 8'd0);
                ifa_d   = (ifr_d != '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            index_q     <= 3'd0;
            ppos_q      <= 16'd0;
            psize_q     <= 16'd0;
            pmov_q      <= 1'b0;
            dmg_flag_q  <= 1'b0;
            heal_flag_q <= 1'b0;
            hp_q        <= HpMax;
            ifr_q       <= '0;
            hit_q       <= 1'b0;
            heal_q      <= 1'b0;
            done_q      <= 1'b0;
            dead_q      <= 1'b0;
            ifa_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            ppos_q      <= ppos_d;
            psize_q     <= psize_d;
            pmov_q      <= pmov_d;
            dmg_flag_q  <= dmg_flag_d;
            heal_flag_q <= heal_flag_d;
            hp_q        <= hp_d;
            ifr_q       <= ifr_d;
            hit_q       <= hit_d;
            heal_q      <= heal_d;
            done_q      <= done_d;
            dead_q      <= dead_d;
            ifa_q       <= ifa_d;
        end
    end

    assign bullet_index  = index_q;
    assign hp            = hp_q;
    assign hit           = hit_q;
    assign heal          = heal_q;
    assign dead          = dead_q;
    assign iframe_active = ifa_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Scoreboard bench for bullet_hit_scanner: a frame-level reference model predicts each committed
// result; a monitor pops predictions whenever done pulses.
module tb_bullet_hit_scanner;

    localparam int HP_MAX  = 20;
    localparam int DAMAGE  = 4;
    localparam int HEAL    = 1;
    localparam int IFRAMES = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  bullet_index;
    logic [15:0] bullet_position;
    logic [15:0] bullet_size;
    logic [2:0]  bullet_color;
    logic        bullet_render;
    logic [15:0] player_position;
    logic [15:0] player_size;
    logic        player_moving;
    logic [7:0]  hp;
    logic        hit, heal, dead, iframe_active, busy, done;

    // Bullet table seen through the collision read port.
    logic [7:0] t_x [8];
    logic [7:0] t_y [8];
    logic [7:0] t_w [8];
    logic [7:0] t_h [8];
    logic [2:0] t_col [8];
    logic       t_ren [8];
    logic [7:0] p_x, p_y, p_w, p_h;
    logic       p_mov;

    assign bullet_position = {t_x[bullet_index], t_y[bullet_index]};
    assign bullet_size     = {t_w[bullet_index], t_h[bullet_index]};
    assign bullet_color    = t_col[bullet_index];
    assign bullet_render   = t_ren[bullet_index];
    assign player_position = {p_x, p_y};
    assign player_size     = {p_w, p_h};
    assign player_moving   = p_mov;

    bullet_hit_scanner #(
        .HP_MAX (HP_MAX),
        .DAMAGE (DAMAGE),
        .HEAL   (HEAL),
        .IFRAMES(IFRAMES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bullet_index   (bullet_index),
        .bullet_position(bullet_position),
        .bullet_size    (bullet_size),
        .bullet_color   (bullet_color),
        .bullet_render  (bullet_render),
        .player_position(player_position),
        .player_size    (player_size),
        .player_moving  (player_moving),
        .hp             (hp),
        .hit            (hit),
        .heal           (heal),
        .dead           (dead),
        .iframe_active  (iframe_active),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hp;
        logic       hit;
        logic       heal;
        logic       dead;
        logic       ifa;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state at frame granularity.
    int m_hp;
    int m_iframe;
    bit m_dead;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit boxes_overlap(input int bx, input int by, input int bw, input int bh,
                                         input int px, input int py, input int pw, input int ph);
        if (bw == 0 || bh == 0 || pw == 0 || ph == 0) return 1'b0;
        return (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
    endfunction

    task automatic model_reset();
        m_hp     = HP_MAX;
        m_iframe = 0;
        m_dead   = 1'b0;
        exp_q.delete();
    endtask

    task automatic predict_frame();
        exp_t e;
        bit   dmg = 1'b0;
        bit   hl  = 1'b0;
        int   had;
        int   nhp;
        for (int s = 0; s < 8; s++) begin
            if (t_ren[s] && boxes_overlap(t_x[s], t_y[s], t_w[s], t_h[s], p_x, p_y, p_w, p_h)) begin
                if (t_col[s] == 3'd0) dmg = 1'b1;
                else if (t_col[s] == 3'd2 && p_mov) dmg = 1'b1;
                else if (t_col[s] == 3'd1) hl = 1'b1;
            end
        end
        e.hit  = 1'b0;
        e.heal = 1'b0;
        had    = m_iframe;
        if (!m_dead) begin
            if (dmg && had == 0) begin
                m_hp  = (m_hp > DAMAGE) ? m_hp - DAMAGE : 0;
                e.hit = 1'b1;
            end else if (!dmg && hl) begin
                nhp    = (m_hp + HEAL > HP_MAX) ? HP_MAX : m_hp + HEAL;
                e.heal = (nhp != m_hp);
                m_hp   = nhp;
            end
        end
        m_iframe = e.hit ? IFRAMES : (had > 0 ? had - 1 : 0);
        if (m_hp == 0) m_dead = 1'b1;
        e.hp   = 8'(m_hp);
        e.dead = m_dead;
        e.ifa  = (m_iframe > 0);
        exp_q.push_back(e);
    endtask

    // Monitor: compare on every done, and require hit/heal to stay low otherwise.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    a = '{hp: hp, hit: hit, heal: heal, dead: dead, ifa: iframe_active};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_done: got done=1, required no pending frame");
                    end else begin
                        e = exp_q.pop_front();
                        if (a != e) begin
                            n_bad++;
                            $display("FAIL frame_result: got hp=%0d hit=%0b heal=%0b dead=%0b ifa=%0b, required hp=%0d hit=%0b heal=%0b dead=%0b ifa=%0b",
                                     a.hp, a.hit, a.heal, a.dead, a.ifa,
                                     e.hp, e.hit, e.heal, e.dead, e.ifa);
                        end
                    end
                end else begin
                    chk("no_pulse_without_done", {30'd0, hit, heal}, 0);
                end
            end
        end
    end

    task automatic clear_table();
        for (int s = 0; s < 8; s++) begin
            t_x[s] = 8'd0; t_y[s] = 8'd0; t_w[s] = 8'd0; t_h[s] = 8'd0;
            t_col[s] = 3'd0; t_ren[s] = 1'b0;
        end
    endtask

    task automatic set_slot(input int s, input int x, input int y, input int w, input int h,
                            input int col);
        t_x[s] = 8'(x); t_y[s] = 8'(y); t_w[s] = 8'(w); t_h[s] = 8'(h);
        t_col[s] = 3'(col); t_ren[s] = 1'b1;
    endtask

    task automatic run_frame();
        predict_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            chk("bullet_index_step", bullet_index, k % 8);
            chk("busy_during_scan", busy, 1);
            @(posedge clk);
            #1;
        end
        chk("busy_after_commit", busy, 0);
        @(posedge clk);
        #1;
        chk("frame_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    task automatic drain_iframes();
        clear_table();
        while (m_iframe > 0) run_frame();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_table();
        p_x = 8'd100; p_y = 8'd100; p_w = 8'd16; p_h = 8'd16; p_mov = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_hp", hp, HP_MAX);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dead", dead, 0);
        chk("reset_iframe", iframe_active, 0);
        chk("reset_index", bullet_index, 0);
        rst = 1'b0;

        // First white hit, then 30 absorbed frames, then a second hit.
        set_slot(2, 108, 108, 4, 4, 0);
        run_frame();
        chk("first_hit_hp", hp, 16);
        chk("first_hit_iframe", iframe_active, 1);
        run_frames(30);
        chk("absorbed_hp", hp, 16);
        chk("iframes_expired", iframe_active, 0);
        run_frame();
        chk("second_hit_hp", hp, 12);

        // Blue only hurts a moving player.
        drain_iframes();
        set_slot(0, 108, 108, 4, 4, 2);
        p_mov = 1'b0;
        run_frame();
        chk("blue_still_hp", hp, 12);
        p_mov = 1'b1;
        run_frame();
        chk("blue_moving_hp", hp, 8);
        p_mov = 1'b0;

        // Healing up to the ceiling, then damage priority over heal.
        do_reset();
        clear_table();
        set_slot(2, 108, 108, 4, 4, 0);
        run_frame();
        clear_table();
        set_slot(3, 104, 104, 4, 4, 1);
        run_frames(3);
        chk("heal_to_19", hp, 19);
        run_frames(2);
        chk("heal_ceiling", hp, 20);
        drain_iframes();
        set_slot(3, 104, 104, 4, 4, 1);
        set_slot(5, 110, 110, 4, 4, 0);
        run_frame();
        chk("damage_beats_heal", hp, 16);

        // Touching edge versus one-pixel overlap.
        drain_iframes();
        set_slot(1, 116, 100, 4, 4, 0);
        run_frame();
        chk("touch_edge_no_hit", hp, 16);
        set_slot(1, 115, 100, 4, 4, 0);
        run_frame();
        chk("overlap_edge_hit", hp, 12);

        // Hit down to zero; dead is sticky and blocks healing.
        while (!m_dead) begin
            drain_iframes();
            set_slot(4, 100, 100, 8, 8, 0);
            run_frame();
        end
        chk("dead_hp", hp, 0);
        chk("dead_flag", dead, 1);
        clear_table();
        set_slot(6, 104, 104, 4, 4, 1);
        run_frames(2);
        chk("dead_no_heal", hp, 0);

        // Reset at E4 aborts the scan with no commit.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midscan_reset_hp", hp, HP_MAX);
        chk("midscan_reset_busy", busy, 0);
        chk("midscan_reset_dead", dead, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midscan_no_done_busy", busy, 0);

        // Randomized frames against the model.
        for (int f = 0; f < 220; f++) begin
            if (f % 60 == 59) do_reset();
            p_x   = 8'($urandom_range(60, 140));
            p_y   = 8'($urandom_range(60, 140));
            p_w   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            p_h   = 8'($urandom_range(1, 24));
            p_mov = 1'($urandom_range(0, 1));
            for (int s = 0; s < 8; s++) begin
                t_x[s]   = 8'($urandom_range(50, 160));
                t_y[s]   = 8'($urandom_range(50, 160));
                t_w[s]   = 8'($urandom_range(0, 16));
                t_h[s]   = 8'($urandom_range(0, 16));
                t_col[s] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7))
                                                       : 3'($urandom_range(0, 2));
                t_ren[s] = ($urandom_range(0, 3) != 0);
            end
            run_frame();
        end

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
